// File: rtl/fp_sign_inject_pipe_if.sv
// ---------------------------------------------------------------------------
// riscv_pkg + fp_sign_inject_pipe_if
//
// riscv_pkg holds the decoded FP operation enumeration shared by the
// sign-inject pipe and its environment.
//
// fp_sign_inject_pipe_if bundles the request and response signals of the
// sign-inject pipe.
//   Request  (master -> slave): i_valid, i_operand_a, i_operand_b,
//                               i_operation, i_tag
//   Response (slave -> master): o_result, o_valid, o_tag
//
// Handshake: valid-only, with no ready. The slave takes a request in every
// cycle where i_valid=1 and the op is one it supports. It never stalls the
// master. o_valid is a one-cycle pulse per accepted op. o_result and o_tag
// are meaningful only while o_valid=1.
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    FADD_S   = 6'd1,
    FSUB_S   = 6'd2,
    FMUL_S   = 6'd3,
    FDIV_S   = 6'd4,
    FSGNJ_S  = 6'd5,
    FSGNJN_S = 6'd6,
    FSGNJX_S = 6'd7,
    FMIN_S   = 6'd8,
    FMAX_S   = 6'd9,
    FADD_D   = 6'd10,
    FSUB_D   = 6'd11,
    FMUL_D   = 6'd12,
    FSGNJ_D  = 6'd13,
    FSGNJN_D = 6'd14,
    FSGNJX_D = 6'd15,
    FMV_X_W  = 6'd16
  } instr_op_e;

endpackage

interface fp_sign_inject_pipe_if #(
  parameter int FLEN      = 32,
  parameter int TAG_WIDTH = 5
);

  logic                      i_valid;
  logic [FLEN-1:0]           i_operand_a;
  logic [FLEN-1:0]           i_operand_b;
  riscv_pkg::instr_op_e      i_operation;
  logic [TAG_WIDTH-1:0]      i_tag;

  logic [FLEN-1:0]           o_result;
  logic                      o_valid;
  logic [TAG_WIDTH-1:0]      o_tag;

  modport master (
    output i_valid, i_operand_a, i_operand_b, i_operation, i_tag,
    input  o_result, o_valid, o_tag
  );

  modport slave (
    input  i_valid, i_operand_a, i_operand_b, i_operation, i_tag,
    output o_result, o_valid, o_tag
  );

endinterface

// File: rtl/fp_sign_inject_pipe.sv
// ---------------------------------------------------------------------------
// fp_sign_inject_pipe
//
// This is a pipelined FSGNJ / FSGNJN / FSGNJX unit. The result is computed
// combinationally when the op is accepted. It then travels through LATENCY
// register stages, and the last stage drives the outputs.
//
// Parameters
//   FLEN      : FP register width, 32 or 64
//   LATENCY   : cycles from accept to o_valid, 1..4
//   TAG_WIDTH : width of the opaque tag carried with each op
//
// Ports
//   i_clk   : clock. All state updates on the rising edge.
//   i_rst   : synchronous, active-high reset. Clears valids and outputs.
//   i_flush : kills every in-flight op. An op offered in the same cycle
//             is not accepted.
//   io      : request/response bundle (slave side).
//   o_busy  : an op is in flight and has not reached the output stage yet.
//
// Handshake: valid-only, with no back-pressure. An op is accepted when
// i_valid=1, the op is supported, and neither i_flush nor i_rst is high.
// Exactly LATENCY cycles later, o_valid pulses for one cycle. Ops emerge
// in order.
// ---------------------------------------------------------------------------
module fp_sign_inject_pipe #(
  parameter int FLEN      = 32,
  parameter int LATENCY   = 1,
  parameter int TAG_WIDTH = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  fp_sign_inject_pipe_if.slave    io,
  output logic                    o_busy
);

  import riscv_pkg::*;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC00000;

  typedef enum logic [1:0] {
    K_J  = 2'd0,  // sign = sb
    K_JN = 2'd1,  // sign = ~sb
    K_JX = 2'd2   // sign = sa ^ sb
  } kind_e;

  // Sign selection common to every flavour and precision.
  function automatic logic inject_sign(input kind_e kind, input logic sa, input logic sb);
    logic s;
    case (kind)
      K_JN:    s = ~sb;
      K_JX:    s = sa ^ sb;
      default: s = sb;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic  w_is_single;
  logic  w_is_double;
  kind_e w_kind;
  logic  w_accept;

  always_comb begin
    w_is_single = 1'b0;
    w_is_double = 1'b0;
    w_kind      = K_J;
    case (io.i_operation)
      FSGNJ_S:  begin w_is_single = 1'b1; w_kind = K_J;  end
      FSGNJN_S: begin w_is_single = 1'b1; w_kind = K_JN; end
      FSGNJX_S: begin w_is_single = 1'b1; w_kind = K_JX; end
      // Double-precision ops exist only on a 64-bit register file.
      FSGNJ_D:  begin w_is_double = (FLEN == 64); w_kind = K_J;  end
      FSGNJN_D: begin w_is_double = (FLEN == 64); w_kind = K_JN; end
      FSGNJX_D: begin w_is_double = (FLEN == 64); w_kind = K_JX; end
      default:  ;
    endcase
  end

  assign w_accept = io.i_valid & (w_is_single | w_is_double) & ~i_flush & ~i_rst;

  // -------------------------------------------------------------------------
  // Result datapath
  // -------------------------------------------------------------------------
  logic [FLEN-1:0] w_result;

  generate
    if (FLEN == 64) begin : g_f64
      logic        w_a_boxed;
      logic        w_b_boxed;
      logic [31:0] w_a32;
      logic        w_b_sign32;
      logic        w_sign_s;
      logic        w_sign_d;

      // A single operand that is not NaN-boxed reads as the canonical NaN.
      // The canonical NaN has sign 0, so b needs only its sign bit.
      assign w_a_boxed  = &io.i_operand_a[63:32];
      assign w_b_boxed  = &io.i_operand_b[63:32];
      assign w_a32      = w_a_boxed ? io.i_operand_a[31:0] : CANON_NAN_S;
      assign w_b_sign32 = w_b_boxed ? io.i_operand_b[31]   : CANON_NAN_S[31];

      assign w_sign_s = inject_sign(w_kind, w_a32[31], w_b_sign32);
      assign w_sign_d = inject_sign(w_kind, io.i_operand_a[63], io.i_operand_b[63]);

      assign w_result = w_is_double ? {w_sign_d, io.i_operand_a[62:0]}
                                    : {32'hFFFFFFFF, w_sign_s, w_a32[30:0]};
    end else begin : g_f32
      assign w_result = {inject_sign(w_kind, io.i_operand_a[31], io.i_operand_b[31]),
                         io.i_operand_a[30:0]};
    end
  endgenerate

  // Only the sign of b contributes to the result.
  logic w_unused_b_mag;
  assign w_unused_b_mag = ^io.i_operand_b[30:0];

  // -------------------------------------------------------------------------
  // Pipeline stages. Stage 0 captures the result at accept, and stage
  // LATENCY-1 drives the outputs. Flush clears the valids only. Data
  // registers move only alongside a live valid, so they hold their values
  // otherwise.
  // -------------------------------------------------------------------------
  logic [LATENCY-1:0]   r_valid;
  logic [FLEN-1:0]      r_result [LATENCY];
  logic [TAG_WIDTH-1:0] r_tag    [LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid[0]  <= 1'b0;
      r_result[0] <= '0;
      r_tag[0]    <= '0;
    end else begin
      r_valid[0] <= w_accept;
      if (w_accept) begin
        r_result[0] <= w_result;
        r_tag[0]    <= io.i_tag;
      end
    end
  end

  generate
    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_valid[k]  <= 1'b0;
          r_result[k] <= '0;
          r_tag[k]    <= '0;
        end else begin
          r_valid[k] <= r_valid[k-1] & ~i_flush;
          if (r_valid[k-1] && !i_flush) begin
            r_result[k] <= r_result[k-1];
            r_tag[k]    <= r_tag[k-1];
          end
        end
      end
    end

    // Busy covers every stage before the output stage.
    if (LATENCY == 1) begin : g_busy_none
      assign o_busy = 1'b0;
    end else begin : g_busy_stages
      assign o_busy = |r_valid[LATENCY-2:0];
    end
  endgenerate

  assign io.o_valid  = r_valid[LATENCY-1];
  assign io.o_result = r_result[LATENCY-1];
  assign io.o_tag    = r_tag[LATENCY-1];

endmodule

// File: doc/fp_sign_inject_pipe.md
FP_SIGN_INJECT_PIPE -- requirements
Module: fp_sign_inject_pipe

Interface
REQ-001 SHALL have parameter FLEN, default 32, FP register width; legal values 32 or 64.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from accept to o_valid; legal range 1..4.
REQ-003 SHALL have parameter TAG_WIDTH, default 5, width of the opaque tag carried with each op.
REQ-004 SHALL have port i_clk  input  1  clock; one clock domain only, all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_valid  input  1  op present this cycle.
REQ-007 SHALL have port i_operand_a  input  FLEN  fs1.
REQ-008 SHALL have port i_operand_b  input  FLEN  fs2.
REQ-009 SHALL have port i_operation  input  riscv_pkg::instr_op_e  decoded op.
REQ-010 SHALL have port i_tag  input  TAG_WIDTH  tag returned with result.
REQ-011 SHALL have port i_flush  input  1  kill all in-flight ops.
REQ-012 SHALL have port o_result  output  FLEN  result.
REQ-013 SHALL have port o_valid  output  1  result valid, one-cycle pulse per op.
REQ-014 SHALL have port o_tag  output  TAG_WIDTH  tag of the op on o_result.
REQ-015 SHALL have port o_busy  output  1  op in flight, not yet at output.

Function
REQ-016 Accept = i_valid & supported op & !i_flush & !i_rst; supported ops: FSGNJ_S, FSGNJN_S, FSGNJX_S always; FSGNJ_D, FSGNJN_D, FSGNJX_D only when FLEN=64.
REQ-017 Unsupported or non-sign-inject ops SHALL be dropped silently: no o_valid, no state change.
REQ-018 Fully pipelined: one accept per cycle, no back-pressure, no initiation-interval gap (back-to-back ops allowed).
REQ-019 An op accepted at edge N SHALL present o_valid=1 for exactly the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after the accept cycle; ops emerge in order.
REQ-020 Sign rule: FSGNJ sign=sb; FSGNJN sign=~sb; FSGNJX sign=sa^sb; magnitude = a's lower bits unchanged.
REQ-021 Double op (FLEN=64): sign bit 63, magnitude a[62:0].
REQ-022 Single op, FLEN=32: sign bit 31, magnitude a[30:0].
REQ-023 Single op, FLEN=64: each operand whose bits [63:32] are not all ones SHALL be replaced by canonical NaN 32'h7FC00000 before the sign rule; result = {32'hFFFFFFFF, 32-bit result} (NaN-boxed).
REQ-024 No exception flags; NaN payloads other than the REQ-023 substitution pass through untouched.
REQ-025 o_tag SHALL equal the i_tag captured at accept, aligned with o_result.
REQ-026 o_result/o_tag when o_valid=0: hold last value; not checked.
REQ-027 o_busy = OR of valid bits of pipeline stages that have not yet reached the output stage; constant 0 when LATENCY=1.
REQ-028 i_flush at edge N SHALL clear every stage valid at edge N; an op offered in the same cycle is not accepted; o_valid=0 in the following cycle.
REQ-029 Flush SHALL not affect data registers; ops accepted after the flush cycle proceed normally.

Reset
REQ-030 i_rst at edge SHALL clear all stage valids; o_valid=0, o_busy=0, o_result=0, o_tag=0 from the next cycle.
REQ-031 Reset mid-operation SHALL discard all in-flight ops; no o_valid for them after reset deasserts.
REQ-032 i_valid during reset SHALL be ignored.

Verification
REQ-033 FLEN=32, LATENCY=1: FSGNJN_S a=32'h3F800000 b=32'h3F800000 tag=3 -> next cycle o_valid=1, o_result=32'hBF800000, o_tag=3.
REQ-034 FLEN=64, LATENCY=3: FSGNJX_D a=64'hC000000000000000 b=64'h8000000000000000 -> o_valid exactly 3 cycles later, o_result=64'h4000000000000000, o_busy=1 in the two intermediate cycles.
REQ-035 FLEN=64: FSGNJ_S a=64'h000000003F800000 (badly boxed) b=64'hFFFFFFFFBF800000 -> o_result=64'hFFFFFFFFFFC00000.
REQ-036 LATENCY=2, four back-to-back ops tags 0..3 -> four consecutive o_valid pulses, tags 0,1,2,3 in order.
REQ-037 LATENCY=3, ops at cycles 0,1, i_flush at cycle 2 with a third op -> no o_valid from any of the three; an op at cycle 3 emerges at cycle 6.
REQ-038 FLEN=32: FSGNJ_D or FADD_S with i_valid=1 -> no o_valid; LATENCY=4 with i_rst asserted mid-flight -> no o_valid afterwards, all outputs 0.
